// File: rtl/order_request_responder_pkg.sv
// Shared order-book package: book entry layout, index widths, opcodes,
// FSM state encoding and a saturating-increment helper.
//
// Contents:
//   STOCK_INDEX, NUM_STOCK_INDEX  stock id width-1 and highest valid stock id
//   ORDER_INDEX, PRICE_INDEX,
//   QUANTITY_INDEX                field widths minus one
//   ADD_ORDER/CANCEL_ORDER/
//   REDUCE_ORDER                  3-bit request opcodes (anything else is rejected)
//   book_entry                    {price, order_id, quantity}
//   resp_state_t                  responder FSM states
//   sat_inc16                     16-bit saturating increment
package order_request_responder_pkg;

  localparam int STOCK_INDEX     = 1;  // stock ids are 2 bits wide
  localparam int NUM_STOCK_INDEX = 2;  // stocks 0..2 exist; id 3 is out of range
  localparam int ORDER_INDEX     = 7;
  localparam int PRICE_INDEX     = 7;
  localparam int QUANTITY_INDEX  = 7;

  localparam logic [STOCK_INDEX:0] LAST_STOCK = (STOCK_INDEX + 1)'(NUM_STOCK_INDEX);

  localparam logic [2:0] ADD_ORDER    = 3'd1;
  localparam logic [2:0] CANCEL_ORDER = 3'd2;
  localparam logic [2:0] REDUCE_ORDER = 3'd3;

  typedef struct packed {
    logic [PRICE_INDEX:0]    price;
    logic [ORDER_INDEX:0]    order_id;
    logic [QUANTITY_INDEX:0] quantity;
  } book_entry;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_APPLY = 3'd2,
    ST_BEST  = 3'd3,
    ST_DONE  = 3'd4
  } resp_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/order_request_responder_book_slot_array.sv
// book_slot_array: resting-order storage for every stock, addressed by
// {stock, slot}. One combinational read port and one write port per cycle.
// Only the valid bits are reset; entry payloads are don't-care while invalid.
//
// Ports:
//   clk_in, rst_in      clock, asynchronous active-high reset (clears valid bits)
//   rd_addr             {stock, slot} read address
//   rd_entry, rd_valid  stored entry and its valid bit at rd_addr
//   wr_en               write strobe
//   wr_addr             {stock, slot} write address
//   wr_entry, wr_valid  payload and valid bit written when wr_en=1
module book_slot_array
  import order_request_responder_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = STOCK_INDEX + 1 + $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output book_entry         rd_entry,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  book_entry         wr_entry,
  input  logic              wr_valid
);

  // Sized to the full address space so an out-of-range stock id still reads
  // a (never written, always invalid) slot instead of falling off the array.
  localparam int NUM_SLOTS = 1 << ADDR_W;

  book_entry              entries [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   valid;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_addr] <= wr_valid;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      entries[wr_addr] <= wr_entry;
    end
  end

  assign rd_entry = entries[rd_addr];
  assign rd_valid = valid[rd_addr];

endmodule

// File: rtl/order_request_responder.sv
// order_request_responder: applies one ADD / CANCEL / REDUCE request at a time
// to a per-stock order book and maintains the best (highest) resting price of
// every stock.
//
// Request handshake: in IDLE a request is accepted on any rising edge where
// start=1; all request inputs are captured on that edge and is_busy rises.
// While is_busy=1 start is ignored (nothing is queued). Exactly 2*DEPTH+2
// cycles after the start cycle, req_done pulses for one cycle with req_error
// valid alongside it; is_busy falls and best_prices_valid rises on the next
// edge, after which a new start can be sampled.
//
// Flow: IDLE -> SCAN (DEPTH cycles, one slot per cycle) -> APPLY (1 cycle,
// single book write) -> BEST (DEPTH cycles, max price over target stock)
// -> DONE (req_done pulse) -> IDLE. Rejected requests take the same path
// and the same time, but write nothing.
//
// Ports:
//   clk_in, rst_in       clock, asynchronous active-high reset
//   start, request       request strobe and opcode
//   stock_to_add         target stock
//   order_to_add         entry to insert for ADD_ORDER
//   order_id             target order for CANCEL/REDUCE
//   delete               must be 1 with CANCEL_ORDER
//   quantity             reduce amount for REDUCE_ORDER
//   is_busy              request in progress
//   best_price_stocks    best resting price per stock, 0 when empty
//   best_prices_valid    best_price_stocks reflects all completed requests
//   req_done, req_error  completion pulse and reject flag
//   accepted_count,
//   rejected_count       saturating 16-bit request counters, present only
//                        when ORDER_RESP_STATS_EN is defined
module order_request_responder
  import order_request_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start,
  input  logic [2:0]              request,
  input  logic [STOCK_INDEX:0]    stock_to_add,
  input  book_entry               order_to_add,
  input  logic [ORDER_INDEX:0]    order_id,
  input  logic                    delete,
  input  logic [QUANTITY_INDEX:0] quantity,
  output logic                    is_busy,
  output logic [PRICE_INDEX:0]    best_price_stocks [0:NUM_STOCK_INDEX],
  output logic                    best_prices_valid,
  output logic                    req_done,
  output logic                    req_error
`ifdef ORDER_RESP_STATS_EN
  ,
  output logic [15:0]             accepted_count,
  output logic [15:0]             rejected_count
`endif
);

  localparam int SLOT_W = $clog2(DEPTH);
  localparam int ADDR_W = STOCK_INDEX + 1 + SLOT_W;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DEPTH - 1);

  resp_state_t             state;

  // Captured request.
  logic [2:0]              op_r;
  logic [STOCK_INDEX:0]    stock_r;
  book_entry               entry_r;
  logic [ORDER_INDEX:0]    id_r;      // id searched for during SCAN
  logic                    delete_r;
  logic [QUANTITY_INDEX:0] qty_r;

  // Scan results and running maximum.
  logic [SLOT_W-1:0]       cnt;
  logic                    free_found;
  logic [SLOT_W-1:0]       free_slot;
  logic                    match_found;
  logic [SLOT_W-1:0]       match_slot;
  book_entry               match_entry;
  logic                    err_r;
  logic [PRICE_INDEX:0]    best_acc;

  // Slot array ports.
  logic [ADDR_W-1:0]       rd_addr;
  book_entry               rd_entry;
  logic                    rd_valid;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  book_entry               wr_entry;
  logic                    wr_valid;

  logic                    reject;
  logic [PRICE_INDEX:0]    best_next;

  book_slot_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_slots (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_addr  (rd_addr),
    .rd_entry (rd_entry),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_entry (wr_entry),
    .wr_valid (wr_valid)
  );

  // SCAN and BEST both walk the target stock slot by slot with cnt.
  assign rd_addr = {stock_r, cnt};

  assign best_next = (rd_valid && (rd_entry.price > best_acc)) ? rd_entry.price : best_acc;

  // Reject decision from the completed scan, and the single APPLY write.
  always_comb begin
    reject   = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = {stock_r, free_slot};
    wr_entry = entry_r;
    wr_valid = 1'b1;

    if (stock_r > LAST_STOCK) begin
      reject = 1'b1;
    end
    case (op_r)
      ADD_ORDER:    if (!free_found || match_found) reject = 1'b1;
      CANCEL_ORDER: if (!match_found || !delete_r) reject = 1'b1;
      REDUCE_ORDER: if (!match_found || (qty_r == '0)) reject = 1'b1;
      default:      reject = 1'b1;
    endcase

    if ((state == ST_APPLY) && !reject) begin
      wr_en = 1'b1;
      case (op_r)
        CANCEL_ORDER: begin
          wr_addr  = {stock_r, match_slot};
          wr_entry = match_entry;
          wr_valid = 1'b0;
        end
        REDUCE_ORDER: begin
          wr_addr  = {stock_r, match_slot};
          wr_entry = match_entry;
          // Reducing by the full resting quantity or more removes the order.
          if (qty_r >= match_entry.quantity) begin
            wr_valid = 1'b0;
          end else begin
            wr_entry.quantity = match_entry.quantity - qty_r;
          end
        end
        default: ;  // ADD_ORDER uses the defaults: free slot, captured entry
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state             <= ST_IDLE;
      op_r              <= '0;
      stock_r           <= '0;
      entry_r           <= '0;
      id_r              <= '0;
      delete_r          <= 1'b0;
      qty_r             <= '0;
      cnt               <= '0;
      free_found        <= 1'b0;
      free_slot         <= '0;
      match_found       <= 1'b0;
      match_slot        <= '0;
      match_entry       <= '0;
      err_r             <= 1'b0;
      best_acc          <= '0;
      is_busy           <= 1'b0;
      best_prices_valid <= 1'b1;
      req_done          <= 1'b0;
      req_error         <= 1'b0;
      for (int s = 0; s <= NUM_STOCK_INDEX; s++) begin
        best_price_stocks[s] <= '0;
      end
`ifdef ORDER_RESP_STATS_EN
      accepted_count    <= '0;
      rejected_count    <= '0;
`endif
    end else begin
      req_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_r              <= request;
            stock_r           <= stock_to_add;
            entry_r           <= order_to_add;
            id_r              <= (request == ADD_ORDER) ? order_to_add.order_id : order_id;
            delete_r          <= delete;
            qty_r             <= quantity;
            cnt               <= '0;
            free_found        <= 1'b0;
            match_found       <= 1'b0;
            is_busy           <= 1'b1;
            best_prices_valid <= 1'b0;
            state             <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (rd_valid && (rd_entry.order_id == id_r)) begin
            if (!match_found) begin
              match_found <= 1'b1;
              match_slot  <= cnt;
              match_entry <= rd_entry;
            end
          end else if (!rd_valid && !free_found) begin
            free_found <= 1'b1;
            free_slot  <= cnt;
          end
          if (cnt == LAST_SLOT) begin
            cnt   <= '0;
            state <= ST_APPLY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_APPLY: begin
          err_r    <= reject;
          best_acc <= '0;
          state    <= ST_BEST;
        end

        ST_BEST: begin
          best_acc <= best_next;
          if (cnt == LAST_SLOT) begin
            cnt       <= '0;
            req_done  <= 1'b1;
            req_error <= err_r;
            // A rejected request left the book untouched, so the published
            // value stays as it was (this also covers out-of-range stocks).
            if (!err_r) begin
              for (int s = 0; s <= NUM_STOCK_INDEX; s++) begin
                if (int'(stock_r) == s) begin
                  best_price_stocks[s] <= best_next;
                end
              end
            end
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DONE: begin
          is_busy           <= 1'b0;
          best_prices_valid <= 1'b1;
`ifdef ORDER_RESP_STATS_EN
          if (req_error) begin
            rejected_count <= sat_inc16(rejected_count);
          end else begin
            accepted_count <= sat_inc16(accepted_count);
          end
`endif
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_order_request_responder.sv
// Directed testbench for order_request_responder (DEPTH=4).
// Inputs are driven and outputs sampled on the falling clock edge.
// Exercises ORDER_RESP_STATS_EN ports only when that macro is defined.
module tb_order_request_responder;
  import order_request_responder_pkg::*;

  localparam int DEPTH   = 4;
  localparam int LATENCY = 2 * DEPTH + 2;

  // Clock / reset
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  logic                    start = 1'b0;
  logic [2:0]              request = '0;
  logic [STOCK_INDEX:0]    stock_to_add = '0;
  book_entry               order_to_add = '0;
  logic [ORDER_INDEX:0]    order_id = '0;
  logic                    delete = 1'b0;
  logic [QUANTITY_INDEX:0] quantity = '0;
  logic                    is_busy;
  logic [PRICE_INDEX:0]    best_price_stocks [0:NUM_STOCK_INDEX];
  logic                    best_prices_valid;
  logic                    req_done;
  logic                    req_error;
`ifdef ORDER_RESP_STATS_EN
  logic [15:0]             accepted_count;
  logic [15:0]             rejected_count;
`endif

  order_request_responder #(.DEPTH(DEPTH)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .start             (start),
    .request           (request),
    .stock_to_add      (stock_to_add),
    .order_to_add      (order_to_add),
    .order_id          (order_id),
    .delete            (delete),
    .quantity          (quantity),
    .is_busy           (is_busy),
    .best_price_stocks (best_price_stocks),
    .best_prices_valid (best_prices_valid),
    .req_done          (req_done),
    .req_error         (req_error)
`ifdef ORDER_RESP_STATS_EN
    ,
    .accepted_count    (accepted_count),
    .rejected_count    (rejected_count)
`endif
  );

  int total  = 0;
  int passed = 0;

  // Observations from the last issued request.
  logic r_err;
  int   r_busy;
  int   r_done_idx;
  logic r_valid_during;

  // Driver: present the staged request for one cycle, then follow it to
  // completion (bounded). r_done_idx counts falling edges after the start
  // cycle, so a request of latency L reports L-1.
  task automatic issue();
    @(negedge clk_in);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    r_valid_during = best_prices_valid;
    r_busy = 0;
    r_done_idx = -1;
    r_err = 1'bx;
    for (int i = 0; i < 40; i++) begin
      if (!is_busy) break;
      r_busy++;
      if (req_done) begin
        r_done_idx = i;
        r_err = req_error;
      end
      @(negedge clk_in);
    end
  endtask

  task automatic do_add(input logic [1:0] stk, input logic [7:0] price,
                        input logic [7:0] id, input logic [7:0] qty);
    request = ADD_ORDER; stock_to_add = stk;
    order_to_add.price = price; order_to_add.order_id = id; order_to_add.quantity = qty;
    order_id = 8'hEE; delete = 1'b0; quantity = '0;
    issue();
  endtask

  task automatic do_cancel(input logic [1:0] stk, input logic [7:0] id, input logic del);
    request = CANCEL_ORDER; stock_to_add = stk; order_to_add = '0;
    order_id = id; delete = del; quantity = '0;
    issue();
  endtask

  task automatic do_reduce(input logic [1:0] stk, input logic [7:0] id, input logic [7:0] qty);
    request = REDUCE_ORDER; stock_to_add = stk; order_to_add = '0;
    order_id = id; delete = 1'b0; quantity = qty;
    issue();
  endtask

  task automatic do_raw(input logic [2:0] op, input logic [1:0] stk);
    request = op; stock_to_add = stk;
    order_to_add.price = 8'd200; order_to_add.order_id = 8'd9; order_to_add.quantity = 8'd1;
    order_id = 8'd9; delete = 1'b1; quantity = 8'd1;
    issue();
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    total++; if (is_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", is_busy); else passed++;
    total++; if (req_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", req_done); else passed++;
    total++; if (req_error !== 1'b0) $display("FAIL reset_error: got %b expected 0", req_error); else passed++;
    total++; if (best_prices_valid !== 1'b1) $display("FAIL reset_valid: got %b expected 1", best_prices_valid); else passed++;
    for (int s = 0; s <= NUM_STOCK_INDEX; s++) begin
      total++;
      if (best_price_stocks[s] !== 8'd0) $display("FAIL reset_best%0d: got %0d expected 0", s, best_price_stocks[s]);
      else passed++;
    end
  endtask

  task automatic test_first_add();
    do_add(2'd0, 8'd2, 8'd2, 8'd2);
    total++; if (r_busy !== LATENCY) $display("FAIL add1_busy_cycles: got %0d expected %0d", r_busy, LATENCY); else passed++;
    total++; if (r_done_idx !== LATENCY - 1) $display("FAIL add1_done_at: got %0d expected %0d", r_done_idx, LATENCY - 1); else passed++;
    total++; if (r_err !== 1'b0) $display("FAIL add1_err: got %b expected 0", r_err); else passed++;
    total++; if (r_valid_during !== 1'b0) $display("FAIL add1_valid_during: got %b expected 0", r_valid_during); else passed++;
    total++; if (best_prices_valid !== 1'b1) $display("FAIL add1_valid_after: got %b expected 1", best_prices_valid); else passed++;
    total++; if (best_price_stocks[0] !== 8'd2) $display("FAIL add1_best0: got %0d expected 2", best_price_stocks[0]); else passed++;
    total++; if (best_price_stocks[1] !== 8'd0) $display("FAIL add1_best1: got %0d expected 0", best_price_stocks[1]); else passed++;
    total++; if (best_price_stocks[2] !== 8'd0) $display("FAIL add1_best2: got %0d expected 0", best_price_stocks[2]); else passed++;
  endtask

  task automatic test_add_cancel();
    int exp_best [4] = '{4, 4, 4, 2};
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: do_add(2'd0, 8'd4, 8'd3, 8'd2);
        1: do_add(2'd0, 8'd4, 8'd4, 8'd2);
        2: do_cancel(2'd0, 8'd4, 1'b1);
        default: do_cancel(2'd0, 8'd3, 1'b1);
      endcase
      total++; if (r_err !== 1'b0) $display("FAIL addcan%0d_err: got %b expected 0", k, r_err); else passed++;
      total++;
      if (best_price_stocks[0] !== 8'(exp_best[k]))
        $display("FAIL addcan%0d_best0: got %0d expected %0d", k, best_price_stocks[0], exp_best[k]);
      else passed++;
    end
  endtask

  task automatic test_full_stock();
    int   exp_best [5] = '{10, 20, 30, 40, 40};
    logic exp_err  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      do_add(2'd1, 8'(10 * (k + 1)), 8'(k + 1), 8'd1);
      total++; if (r_err !== exp_err[k]) $display("FAIL full%0d_err: got %b expected %b", k, r_err, exp_err[k]); else passed++;
      total++;
      if (best_price_stocks[1] !== 8'(exp_best[k]))
        $display("FAIL full%0d_best1: got %0d expected %0d", k, best_price_stocks[1], exp_best[k]);
      else passed++;
    end
    total++; if (r_busy !== LATENCY) $display("FAIL full_reject_busy: got %0d expected %0d", r_busy, LATENCY); else passed++;
  endtask

  task automatic test_reduce();
    do_reduce(2'd0, 8'd2, 8'd1);
    total++; if (r_err !== 1'b0) $display("FAIL reduce1_err: got %b expected 0", r_err); else passed++;
    total++; if (best_price_stocks[0] !== 8'd2) $display("FAIL reduce1_best0: got %0d expected 2", best_price_stocks[0]); else passed++;
    do_reduce(2'd0, 8'd2, 8'd5);
    total++; if (r_err !== 1'b0) $display("FAIL reduce2_err: got %b expected 0", r_err); else passed++;
    total++; if (best_price_stocks[0] !== 8'd0) $display("FAIL reduce2_best0: got %0d expected 0", best_price_stocks[0]); else passed++;
    do_cancel(2'd0, 8'd2, 1'b1);
    total++; if (r_err !== 1'b1) $display("FAIL cancel_gone_err: got %b expected 1", r_err); else passed++;
    total++; if (best_price_stocks[0] !== 8'd0) $display("FAIL cancel_gone_best0: got %0d expected 0", best_price_stocks[0]); else passed++;
  endtask

  task automatic test_errors();
    do_add(2'd2, 8'd7, 8'd9, 8'd1);
    total++; if (r_err !== 1'b0) $display("FAIL err_seed_err: got %b expected 0", r_err); else passed++;
    total++; if (best_price_stocks[2] !== 8'd7) $display("FAIL err_seed_best2: got %0d expected 7", best_price_stocks[2]); else passed++;
    // Each case below must be rejected and leave stock 2 at 7.
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: do_add(2'd2, 8'd50, 8'd9, 8'd1);   // duplicate id in stock
        1: do_cancel(2'd2, 8'd9, 1'b0);       // delete flag low
        2: do_raw(ADD_ORDER, 2'd3);           // stock out of range
        3: do_raw(3'd0, 2'd2);                // unknown opcode
        4: do_raw(3'd7, 2'd2);                // unknown opcode
        5: do_reduce(2'd2, 8'd9, 8'd0);       // zero reduce
        default: do_reduce(2'd2, 8'd33, 8'd1); // no such order
      endcase
      total++; if (r_err !== 1'b1) $display("FAIL err%0d_err: got %b expected 1", k, r_err); else passed++;
      total++; if (best_price_stocks[2] !== 8'd7) $display("FAIL err%0d_best2: got %0d expected 7", k, best_price_stocks[2]); else passed++;
      total++; if (r_done_idx !== LATENCY - 1) $display("FAIL err%0d_done_at: got %0d expected %0d", k, r_done_idx, LATENCY - 1); else passed++;
    end
    // Same id in another stock is a distinct order.
    do_add(2'd0, 8'd3, 8'd9, 8'd1);
    total++; if (r_err !== 1'b0) $display("FAIL per_stock_err: got %b expected 0", r_err); else passed++;
    total++; if (best_price_stocks[0] !== 8'd3) $display("FAIL per_stock_best0: got %0d expected 3", best_price_stocks[0]); else passed++;
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    int done_at [2] = '{-1, -1};
    logic errs [2] = '{1'bx, 1'bx};
    logic busy_11 = 1'bx;
    logic busy_12 = 1'bx;
    request = ADD_ORDER; stock_to_add = 2'd2;
    order_to_add.price = 8'd5; order_to_add.order_id = 8'd20; order_to_add.quantity = 8'd1;
    @(negedge clk_in);
    start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk_in);
      if (n == 16) start = 1'b0;
      if (n == 11) busy_11 = is_busy;
      if (n == 12) busy_12 = is_busy;
      if (req_done) begin
        if (done_cnt < 2) begin
          done_at[done_cnt] = n;
          errs[done_cnt] = req_error;
        end
        done_cnt++;
      end
    end
    total++; if (done_cnt !== 2) $display("FAIL b2b_count: got %0d expected 2", done_cnt); else passed++;
    total++; if (done_at[0] !== 10) $display("FAIL b2b_first_done: got %0d expected 10", done_at[0]); else passed++;
    total++; if (done_at[1] !== 21) $display("FAIL b2b_second_done: got %0d expected 21", done_at[1]); else passed++;
    total++; if (busy_11 !== 1'b0) $display("FAIL b2b_idle_gap: got %b expected 0", busy_11); else passed++;
    total++; if (busy_12 !== 1'b1) $display("FAIL b2b_restart: got %b expected 1", busy_12); else passed++;
    total++; if (errs[0] !== 1'b0) $display("FAIL b2b_first_err: got %b expected 0", errs[0]); else passed++;
    total++; if (errs[1] !== 1'b1) $display("FAIL b2b_second_err: got %b expected 1", errs[1]); else passed++;
    total++; if (best_price_stocks[2] !== 8'd7) $display("FAIL b2b_best2: got %0d expected 7", best_price_stocks[2]); else passed++;
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0;
    request = ADD_ORDER; stock_to_add = 2'd1;
    order_to_add.price = 8'd99; order_to_add.order_id = 8'd6; order_to_add.quantity = 8'd1;
    @(negedge clk_in);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    total++; if (is_busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", is_busy); else passed++;
    total++; if (best_prices_valid !== 1'b1) $display("FAIL rstmid_valid: got %b expected 1", best_prices_valid); else passed++;
    for (int s = 0; s <= NUM_STOCK_INDEX; s++) begin
      total++;
      if (best_price_stocks[s] !== 8'd0) $display("FAIL rstmid_best%0d: got %0d expected 0", s, best_price_stocks[s]);
      else passed++;
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk_in);
      if (req_done) done_cnt++;
    end
    total++; if (done_cnt !== 0) $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt); else passed++;
    // Book was wiped: id 1 in stock 1 is free again.
    do_add(2'd1, 8'd5, 8'd1, 8'd1);
    total++; if (r_err !== 1'b0) $display("FAIL rstmid_readd_err: got %b expected 0", r_err); else passed++;
    total++; if (best_price_stocks[1] !== 8'd5) $display("FAIL rstmid_readd_best1: got %0d expected 5", best_price_stocks[1]); else passed++;
`ifdef ORDER_RESP_STATS_EN
    total++; if (accepted_count !== 16'd1) $display("FAIL stats_accepted: got %0d expected 1", accepted_count); else passed++;
    total++; if (rejected_count !== 16'd0) $display("FAIL stats_rejected: got %0d expected 0", rejected_count); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_first_add();
    test_add_cancel();
    test_full_stock();
    test_reduce();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
